prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle MIPS core. It receives a byte stream (header, payload, checksum) over a valid/ready interface and assembles the bytes into 32-bit instruction words. It writes those words into instruction memory through a dedicated write port, and holds the core in reset until a complete, checksum-verified image has been written.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/byte_packer.sv | 38 +++
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encoding is exported so checkers can bind to it directly.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_HDR  = 3'd1,
      LD_LOAD = 3'd2,
      LD_CHK  = 3'd3,
      LD_DONE = 3'd4,
      LD_ERR  = 3'd5
   } ld_state_e;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses
// combinationally with the 4th byte so the caller can register the result.
module byte_packer import prog_loader_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int CW = $clog2(BYTES_PER_WORD);
   localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

   logic [CW-1:0] cnt;
   logic [23:0]   acc;

   // The top byte is never stored: it is forwarded straight into word.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
         acc <= '0;
      end else if (byte_valid) begin
         cnt <= cnt + CW'(1);
         case (cnt)
            CW'(0):  acc[7:0]   <= byte_data;
            CW'(1):  acc[15:8]  <= byte_data;
            CW'(2):  acc[23:16] <= byte_data;
            default: ;
         endcase
      end
   end

   assign word_valid = byte_valid && (cnt == LAST);
   assign word       = {byte_data, acc};

endmodule

// File: rtl/prog_loader.sv
// Loads a header/payload/checksum byte stream into instruction memory and
// holds the core in reset until a checksum-verified image is in place.
module prog_loader import prog_loader_pkg::*; #(
   parameter int MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err,
   output ld_state_e   state
);

   // Handshake: a byte moves when rx_valid && rx_ready at a rising edge;
   // rx_ready is registered and stays high across memory write cycles.

   localparam int IW = 17;

   logic          byte_valid;
   logic          pk_clear;
   logic          word_valid;
   logic [31:0]   word;
   logic [IW-1:0] idx;
   logic [IW-1:0] n;
   logic [31:0]   sum;
   logic          can_start;
   logic          hdr_bad;
   logic          last_word;

   assign byte_valid = rx_valid && rx_ready;
   assign can_start  = (state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR);
   assign pk_clear   = start && can_start;
   assign hdr_bad    = (word == 32'd0) || (word > 32'(MAX_WORDS));
   assign last_word  = (idx == n - IW'(1));

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pk_clear),
      .byte_valid (byte_valid),
      .byte_data  (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LD_IDLE;
         rx_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         idx        <= '0;
         n          <= '0;
         sum        <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
               if (start) begin
                  state    <= LD_HDR;
                  idx      <= '0;
                  sum      <= '0;
                  rx_ready <= 1'b1;
                  busy     <= 1'b1;
                  cpu_rst  <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            LD_HDR: begin
               if (word_valid) begin
                  n <= word[IW-1:0];
                  if (hdr_bad) begin
                     state    <= LD_ERR;
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= LD_LOAD;
                  end
               end
            end
            LD_LOAD: begin
               if (word_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= 32'({idx, 2'b00});
                  imem_wdata <= word;
                  sum        <= sum + word;
                  idx        <= idx + IW'(1);
                  if (last_word) state <= LD_CHK;
               end
            end
            LD_CHK: begin
               if (word_valid) begin
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (word == sum) begin
                     state   <= LD_DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                  end else begin
                     state <= LD_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= LD_IDLE;
               rx_ready <= 1'b0;
               busy     <= 1'b0;
               cpu_rst  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of image scenarios checked against a
// word-level model of the load protocol, plus a reset-mid-load sequence.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int MAX = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;
   ld_state_e   state;

   prog_loader #(.MAX_WORDS(MAX)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .state      (state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] img [0:MAX];
   logic [63:0] exp_q [$];
   logic [63:0] act_q [$];
   bit inject_start = 1'b0;

   typedef struct {
      logic [31:0] hdr;
      bit          bad_chk;
      int          max_gap;
      bit          start_mid;
      bit          exp_done;
      int          exp_writes;
   } vec_t;

   vec_t vecs [9];

   always @(negedge clk)
      if (imem_we === 1'b1) act_q.push_back({imem_addr, imem_wdata});

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int g;
      int guard;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
         @(negedge clk);
         rx_valid = 1'b0;
         start = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      start = inject_start;
      inject_start = 1'b0;
      guard = 0;
      while (!rx_ready && guard < 50) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
      end
      if (!rx_ready) chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
   endtask

   task automatic set_happy();
      img[0] = 32'h20080005;
      img[1] = 32'h01095020;
   endtask

   // Word-level reference: valid header writes every payload word in order,
   // success iff the checksum equals the modulo-2^32 sum of the payload.
   task automatic run_image(input logic [31:0] hdr, input logic [31:0] cks,
                            input int gap, input bit start_mid,
                            input bit tbl_done, input int tbl_writes);
      bit hdr_ok;
      logic [31:0] s;
      bit m_done;
      hdr_ok = (hdr != 0) && (hdr <= MAX);
      s = 32'd0;
      exp_q.delete();
      act_q.delete();
      if (hdr_ok)
         for (int i = 0; i < int'(hdr); i++) begin
            exp_q.push_back({32'(i * 4), img[i]});
            s = s + img[i];
         end
      m_done = hdr_ok && (s == cks);
      chk("table_vs_model", {63'd0, tbl_done}, {63'd0, m_done});

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_rx_ready", {63'd0, rx_ready}, 64'd1);
      chk("start_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("start_busy", {63'd0, busy}, 64'd1);
      chk("start_done", {63'd0, done}, 64'd0);

      send_word(hdr, gap);
      if (hdr_ok) begin
         for (int i = 0; i < int'(hdr); i++) begin
            if (start_mid && i == 0) inject_start = 1'b1;
            send_word(img[i], gap);
         end
         send_word(cks, gap);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      chk("end_done", {63'd0, done}, {63'd0, m_done});
      chk("end_err", {63'd0, err}, {63'd0, !m_done});
      chk("end_cpu_rst", {63'd0, cpu_rst}, {63'd0, !m_done});
      chk("end_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk("end_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("write_count", 64'(act_q.size()), 64'(tbl_writes));
      chk("model_write_count", 64'(act_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         if (act_q[i] !== exp_q[i]) chk("write_addr_data", act_q[i], exp_q[i]);
      if (hdr == 32'd256 && act_q.size() > 0) chk("last_addr", 64'(act_q[$][63:32]), 64'h3FC);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total + 1, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'd2,   1'b0, 0, 1'b0, 1'b1, 2};
      vecs[1] = '{32'd2,   1'b1, 0, 1'b0, 1'b0, 2};
      vecs[2] = '{32'd0,   1'b0, 0, 1'b0, 1'b0, 0};
      vecs[3] = '{32'd257, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[4] = '{32'd256, 1'b0, 0, 1'b0, 1'b1, 256};
      vecs[5] = '{32'd2,   1'b0, 5, 1'b0, 1'b1, 2};
      vecs[6] = '{32'd5,   1'b0, 0, 1'b1, 1'b1, 5};
      vecs[7] = '{32'd16,  1'b1, 2, 1'b0, 1'b0, 16};
      vecs[8] = '{32'd1,   1'b0, 3, 1'b0, 1'b1, 1};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", 64'(state), 64'(LD_IDLE));
      chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);

      foreach (vecs[v]) begin
         logic [31:0] cks;
         logic [31:0] s;
         s = 32'd0;
         if (vecs[v].hdr == 32'd2) set_happy();
         else for (int i = 0; i < MAX; i++) img[i] = $urandom;
         if (vecs[v].hdr == 32'd2) cks = vecs[v].bad_chk ? 32'h21115026 : 32'h21115025;
         else begin
            for (int i = 0; i < int'(vecs[v].hdr) && i < MAX; i++) s = s + img[i];
            cks = s + (vecs[v].bad_chk ? 32'd1 : 32'd0);
         end
         run_image(vecs[v].hdr, cks, vecs[v].max_gap, vecs[v].start_mid,
                   vecs[v].exp_done, vecs[v].exp_writes);
      end

      // Reset after 6 payload bytes: one write issued, partial word dropped.
      set_happy();
      act_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_word(32'd2, 0);
      send_word(img[0], 0);
      send_byte(img[1][7:0], 0);
      send_byte(img[1][15:8], 0);
      @(negedge clk);
      rx_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_state", 64'(state), 64'(LD_IDLE));
      chk("mid_rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("mid_rst_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_imem_we", {63'd0, imem_we}, 64'd0);
      chk("mid_rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("mid_rst_imem_wdata", 64'(imem_wdata), 64'd0);
      repeat (3) @(negedge clk);
      chk("mid_rst_writes", 64'(act_q.size()), 64'd1);
      run_image(32'd2, 32'h21115025, 1, 1'b0, 1'b1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
